// File: rtl/tnn_csr_sched.sv
// CSR sequencer for the sparse ternary layer: walks row pointers and column indices,
// one non-zero per cycle, and drives clear/issue/commit strobes for the shared MAC.
module tnn_csr_sched #(
  parameter int ROW_CNT  = 6,
  parameter int COL_CNT  = 40,
  parameter int NNZ      = 71,
  parameter int PTR_BITS = 8,
  parameter logic [(ROW_CNT+1)*PTR_BITS-1:0] ROW_PTRS = 56'h473b2921160e00,
  parameter logic [NNZ*8-1:0] COL_INDICES = {
    8'd37, 8'd34, 8'd30, 8'd26, 8'd23, 8'd19, 8'd15, 8'd12, 8'd10, 8'd7, 8'd5, 8'd0,
    8'd39, 8'd36, 8'd33, 8'd31, 8'd29, 8'd27, 8'd24, 8'd22, 8'd20, 8'd18, 8'd14, 8'd13,
    8'd9, 8'd8, 8'd6, 8'd4, 8'd3, 8'd1,
    8'd35, 8'd32, 8'd25, 8'd21, 8'd16, 8'd11, 8'd7, 8'd2,
    8'd38, 8'd36, 8'd34, 8'd31, 8'd24, 8'd19, 8'd15, 8'd10, 8'd6, 8'd3, 8'd0,
    8'd37, 8'd33, 8'd27, 8'd20, 8'd14, 8'd9, 8'd5, 8'd1,
    8'd39, 8'd30, 8'd29, 8'd28, 8'd26, 8'd23, 8'd22, 8'd18, 8'd17, 8'd12, 8'd4, 8'd3,
    8'd2, 8'd0},
  localparam int ROW_W    = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1,
  localparam int COL_W    = (COL_CNT > 1) ? $clog2(COL_CNT) : 1,
  localparam int ROW_IDXW = $clog2(ROW_CNT + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_acc_clr,
  output logic                o_acc_en,
  output logic                o_row_commit,
  output logic [ROW_W-1:0]    o_row_idx,
  output logic [COL_W-1:0]    o_col_idx,
  output logic [PTR_BITS-1:0] o_nz_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WALK,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [ROW_IDXW-1:0] r_row;
  logic [ROW_IDXW-1:0] w_rowNext;
  logic [ROW_IDXW-1:0] w_rowInc;
  logic [ROW_IDXW-1:0] w_rowInc2;
  logic [PTR_BITS-1:0] r_ptr;
  logic [PTR_BITS-1:0] r_end;
  logic [PTR_BITS-1:0] w_ptrNext;
  logic [PTR_BITS-1:0] w_endNext;
  logic [PTR_BITS-1:0] w_ptrInc;

  // Tables are padded to a power of two so the registered indices address them exactly.
  logic [PTR_BITS-1:0] w_rowPtr [2**ROW_IDXW];
  logic [COL_W-1:0]    w_colTab [2**PTR_BITS];

  for (genvar k = 0; k < 2**ROW_IDXW; k++) begin : g_rowPtr
    if (k <= ROW_CNT) begin : g_used
      assign w_rowPtr[k] = ROW_PTRS[k*PTR_BITS +: PTR_BITS];
    end else begin : g_pad
      assign w_rowPtr[k] = '0;
    end
  end

  for (genvar k = 0; k < 2**PTR_BITS; k++) begin : g_colTab
    if (k < NNZ) begin : g_used
      assign w_colTab[k] = COL_INDICES[k*8 +: COL_W];
    end else begin : g_pad
      assign w_colTab[k] = '0;
    end
  end

  assign w_rowInc  = r_row + ROW_IDXW'(1);
  assign w_rowInc2 = r_row + ROW_IDXW'(2);
  assign w_ptrInc  = r_ptr + PTR_BITS'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_ptr   <= '0;
      r_end   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_row   <= w_rowNext;
      r_ptr   <= w_ptrNext;
      r_end   <= w_endNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_rowNext    = r_row;
    w_ptrNext    = r_ptr;
    w_endNext    = r_end;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_acc_clr    = 1'b0;
    o_acc_en     = 1'b0;
    o_row_commit = 1'b0;
    o_row_idx    = r_row[ROW_W-1:0];
    o_col_idx    = '0;
    o_nz_idx     = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_stateNext = S_CLR;
          w_rowNext   = '0;
          w_ptrNext   = w_rowPtr[0];
          w_endNext   = w_rowPtr[1];
        end
      end
      S_CLR: begin
        o_busy    = 1'b1;
        o_acc_clr = 1'b1;
        // A malformed row (end below start) falls through as empty.
        w_stateNext = (r_ptr < r_end) ? S_WALK : S_COMMIT;
      end
      S_WALK: begin
        o_busy    = 1'b1;
        o_acc_en  = 1'b1;
        o_nz_idx  = r_ptr;
        o_col_idx = w_colTab[r_ptr];
        if (i_ready) begin
          w_ptrNext = w_ptrInc;
          if (w_ptrInc == r_end) begin
            w_stateNext = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        o_busy       = 1'b1;
        o_row_commit = 1'b1;
        if (r_row == ROW_IDXW'(ROW_CNT - 1)) begin
          w_stateNext = S_DONE;
        end else begin
          w_stateNext = S_CLR;
          w_rowNext   = w_rowInc;
          w_ptrNext   = w_rowPtr[w_rowInc];
          w_endNext   = w_rowPtr[w_rowInc2];
        end
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_stateNext = S_IDLE;
        w_rowNext   = '0;
        w_ptrNext   = '0;
        w_endNext   = '0;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tnn_csr_sched.sv
// Directed bench for tnn_csr_sched: default pass, backpressure, empty row, reset,
// held start and a single-row/single-non-zero matrix.
module tb_tnn_csr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic startA;
  logic readyA;
  logic startB;
  logic startC;
  logic readyBC;

  logic       aBusy, aDone, aClr, aEn, aCommit;
  logic [2:0] aRow;
  logic [5:0] aCol;
  logic [7:0] aNz;

  logic       bBusy, bDone, bClr, bEn, bCommit;
  logic [2:0] bRow;
  logic [5:0] bCol;
  logic [7:0] bNz;

  logic       cBusy, cDone, cClr, cEn, cCommit;
  logic       cRow;
  logic [5:0] cCol;
  logic [7:0] cNz;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int row0Cols [14] = '{0, 2, 3, 4, 12, 17, 18, 22, 23, 26, 28, 29, 30, 39};

  tnn_csr_sched u_dutA (
    .i_clk(clk), .i_rst(rst), .i_start(startA), .i_ready(readyA),
    .o_busy(aBusy), .o_done(aDone), .o_acc_clr(aClr), .o_acc_en(aEn),
    .o_row_commit(aCommit), .o_row_idx(aRow), .o_col_idx(aCol), .o_nz_idx(aNz)
  );

  // Rows 2 and 3 share a start pointer, so row 2 is empty.
  tnn_csr_sched #(.ROW_PTRS(56'h473b2916160e00)) u_dutB (
    .i_clk(clk), .i_rst(rst), .i_start(startB), .i_ready(readyBC),
    .o_busy(bBusy), .o_done(bDone), .o_acc_clr(bClr), .o_acc_en(bEn),
    .o_row_commit(bCommit), .o_row_idx(bRow), .o_col_idx(bCol), .o_nz_idx(bNz)
  );

  tnn_csr_sched #(.ROW_CNT(1), .NNZ(1), .ROW_PTRS(16'h0100), .COL_INDICES(8'd7)) u_dutC (
    .i_clk(clk), .i_rst(rst), .i_start(startC), .i_ready(readyBC),
    .o_busy(cBusy), .o_done(cDone), .o_acc_clr(cClr), .o_acc_en(cEn),
    .o_row_commit(cCommit), .o_row_idx(cRow), .o_col_idx(cCol), .o_nz_idx(cNz)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int enCount;
  int doneCyc;
  int hold;
  int colErr;
  int seqErr;
  int expNz;
  int stallLeft;
  bit stallSeen;

  initial begin
    rst     = 1'b1;
    startA  = 1'b0;
    startB  = 1'b0;
    startC  = 1'b0;
    readyA  = 1'b1;
    readyBC = 1'b1;
    step();
    step();
    checkVal("rst_busy", 32'(aBusy), 0);
    checkVal("rst_strobes", 32'({aDone, aClr, aEn, aCommit}), 0);
    checkVal("rst_indices", 32'({aRow, aCol, aNz}), 0);
    rst = 1'b0;
    step();

    // Default pass with ready held high.
    startA = 1'b1;
    cyc    = 0;
    step();
    startA = 1'b0;
    checkVal("t1_clr_c1", 32'(aClr), 1);
    checkVal("t1_busy_c1", 32'(aBusy), 1);
    for (int k = 0; k < 14; k++) begin
      step();
      checkVal($sformatf("t1_en_%0d", k), 32'(aEn), 1);
      checkVal($sformatf("t1_nz_%0d", k), 32'(aNz), k);
      checkVal($sformatf("t1_col_%0d", k), 32'(aCol), row0Cols[k]);
    end
    step();
    checkVal("t1_commit_c16", 32'(aCommit), 1);
    checkVal("t1_commit_row", 32'(aRow), 0);
    enCount = 14;
    doneCyc = -1;
    while (doneCyc < 0 && cyc < 120) begin
      step();
      if (aEn) enCount++;
      if (aDone) doneCyc = cyc;
    end
    checkVal("t1_en_total", enCount, 71);
    checkVal("t1_done_cycle", doneCyc, 84);
    checkVal("t1_busy_done", 32'(aBusy), 1);
    step();
    checkVal("t1_idle_after", 32'({aBusy, aDone, aClr}), 0);

    // Backpressure: three stall cycles on the sixth non-zero.
    startA = 1'b1;
    cyc    = 0;
    step();
    startA    = 1'b0;
    enCount   = 0;
    doneCyc   = -1;
    hold      = 0;
    colErr    = 0;
    seqErr    = 0;
    expNz     = 0;
    stallLeft = 0;
    stallSeen = 1'b0;
    while (doneCyc < 0 && cyc < 150) begin
      if (aDone) doneCyc = cyc;
      readyA = 1'b1;
      if (aEn) begin
        if (32'(aNz) != expNz) seqErr++;
        if (aNz == 8'd5) begin
          hold++;
          if (aCol != 6'd17) colErr++;
          if (!stallSeen) begin
            stallSeen = 1'b1;
            stallLeft = 3;
          end
        end
        if (stallLeft > 0) begin
          readyA = 1'b0;
          stallLeft--;
        end
        if (readyA) begin
          expNz++;
          enCount++;
        end
      end
      if (doneCyc < 0) step();
    end
    readyA = 1'b1;
    checkVal("t2_hold_cycles", hold, 4);
    checkVal("t2_hold_col", colErr, 0);
    checkVal("t2_nz_sequence", seqErr, 0);
    checkVal("t2_issue_total", enCount, 71);
    checkVal("t2_done_cycle", doneCyc, 87);
    step();

    // Empty row 2 on the second instance.
    startB = 1'b1;
    cyc    = 0;
    step();
    startB = 1'b0;
    while (cyc < 27) step();
    checkVal("t3_clr_row2", 32'(bClr), 1);
    checkVal("t3_clr_row2_idx", 32'(bRow), 2);
    step();
    checkVal("t3_commit_row2", 32'(bCommit), 1);
    checkVal("t3_no_en_row2", 32'(bEn), 0);
    checkVal("t3_busy_row2", 32'(bBusy), 1);
    step();
    checkVal("t3_clr_row3", 32'({bClr, bRow}), 11);
    step();
    checkVal("t3_row3_first_nz", 32'(bNz), 22);
    checkVal("t3_row3_first_col", 32'(bCol), 0);
    doneCyc = -1;
    while (doneCyc < 0 && cyc < 120) begin
      step();
      if (bDone) doneCyc = cyc;
    end
    checkVal("t3_done_cycle", doneCyc, 84);
    step();

    // Reset in the middle of row 3.
    startA = 1'b1;
    cyc    = 0;
    step();
    startA = 1'b0;
    while (cyc < 42) step();
    checkVal("t4_walk_row3", 32'({aEn, aRow}), 11);
    checkVal("t4_walk_nz", 32'(aNz), 34);
    rst = 1'b1;
    step();
    checkVal("t4_rst_busy", 32'(aBusy), 0);
    checkVal("t4_rst_strobes", 32'({aDone, aClr, aEn, aCommit}), 0);
    checkVal("t4_rst_indices", 32'({aRow, aCol, aNz}), 0);
    rst = 1'b0;
    step();
    checkVal("t4_stays_idle", 32'({aBusy, aCommit, aDone}), 0);
    startA = 1'b1;
    cyc    = 0;
    step();
    startA = 1'b0;
    checkVal("t4_restart_clr", 32'({aClr, aRow}), 8);
    step();
    checkVal("t4_restart_en", 32'(aEn), 1);
    checkVal("t4_restart_nz", 32'(aNz), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Start held high across the whole pass and through DONE.
    startA = 1'b1;
    cyc    = 0;
    step();
    checkVal("t5_clr_c1", 32'(aClr), 1);
    while (cyc < 17) step();
    checkVal("t5_row1_clr", 32'({aClr, aRow}), 9);
    doneCyc = -1;
    while (doneCyc < 0 && cyc < 120) begin
      step();
      if (aDone) doneCyc = cyc;
    end
    checkVal("t5_done_cycle", doneCyc, 84);
    step();
    checkVal("t5_idle_gap", 32'({aBusy, aClr}), 0);
    step();
    checkVal("t5_restart_clr", 32'({aClr, aRow}), 8);
    startA = 1'b0;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    step();

    // One row holding one non-zero.
    startC = 1'b1;
    cyc    = 0;
    step();
    startC = 1'b0;
    checkVal("t6_c1", 32'({cClr, cEn, cCommit, cDone}), 8);
    step();
    checkVal("t6_c2", 32'({cClr, cEn, cCommit, cDone}), 4);
    checkVal("t6_c2_idx", 32'({cCol, cNz}), 7 << 8);
    step();
    checkVal("t6_c3", 32'({cClr, cEn, cCommit, cDone}), 2);
    checkVal("t6_c3_row", 32'(cRow), 0);
    step();
    checkVal("t6_c4", 32'({cClr, cEn, cCommit, cDone}), 1);
    step();
    checkVal("t6_c5_idle", 32'({cBusy, cClr, cEn, cCommit, cDone}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tnn_csr_sched.md
# tnn_csr_sched

Sequencer for the sparse (CSR-encoded) ternary layer of the sequential TNN classifier. It walks the row-pointer and column-index tables one non-zero per cycle and emits the accumulator control for the shared ternary MAC:
- a clear at the start of each row;
- one issue strobe per non-zero, carrying the feature/hidden column index and the non-zero index that selects the sign bit;
- a commit strobe at the end of each row.

It sits between the top-level start/done control and the output-layer accumulator of `seq_tnn`.

## Interface
- `ROW_CNT`, 6, number of CSR rows (output classes)
- `COL_CNT`, 40, number of columns (hidden neurons)
- `NNZ`, 71, total non-zero count
- `PTR_BITS`, 8, width of one `ROW_PTRS` entry and of `nz_idx`
- `ROW_PTRS`, 56'h473b2921160e00, (`ROW_CNT`+1) packed entries; entry k is in bits [k*`PTR_BITS` +: `PTR_BITS`]
- `COL_INDICES`, `NNZ`*8-bit packed, entry k is in bits [k*8 +: 8] (LSB-first)
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one matrix pass; sampled only in IDLE
- `ready`  in  1  accumulator accepts the current issue
- `busy`  out  1  high from the cycle after `start` is accepted through DONE
- `done`  out  1  one-cycle pulse when the pass completes
- `acc_clr`  out  1  clear the accumulator for `row_idx`
- `acc_en`  out  1  issue valid: `col_idx` and `nz_idx` are meaningful
- `row_commit`  out  1  accumulator result for `row_idx` is final
- `row_idx`  out  max(1,$clog2(`ROW_CNT`))  current row
- `col_idx`  out  $clog2(`COL_CNT`)  column of the current non-zero
- `nz_idx`  out  `PTR_BITS`  index into the non-zero sign vector

## Operation
- FSM states: IDLE, CLR, WALK, COMMIT, DONE. All outputs are decoded from registered state, pointer and row. There is no combinational input-to-output path.
- IDLE:
  - All outputs are 0.
  - `start`=1 → CLR, with row=0, ptr=`ROW_PTRS`[0] and end=`ROW_PTRS`[1].
- CLR:
  - `acc_clr`=1 for one cycle.
  - Next state is WALK if ptr<end, otherwise COMMIT (empty row).
- WALK:
  - `acc_en`=1, `nz_idx`=ptr, `col_idx`=`COL_INDICES`[ptr] truncated to $clog2(`COL_CNT`) bits.
  - Handshake: an issue completes on a cycle with `acc_en`&&`ready`. On `ready`=0, `acc_en`, `nz_idx` and `col_idx` hold stable.
  - On completion ptr increments. If ptr+1==end → COMMIT.
- COMMIT:
  - `row_commit`=1 for one cycle; `ready` is ignored.
  - If row==`ROW_CNT`-1 → DONE.
  - Otherwise row+1 → CLR, loading ptr/end from the next pair of `ROW_PTRS` entries.
- DONE: `done`=1 for one cycle, then → IDLE.
- Malformed table (end<start for a row): the row is treated as empty (CLR → COMMIT). No issue is emitted.
- `start` is ignored in every state except IDLE. A `start` held high through DONE starts a new pass from IDLE one cycle later.
- `rst` in any state: next cycle is IDLE, and row, ptr, end and every output are 0. A partial pass is abandoned with no `row_commit` and no `done`.

## Timing
- Reset values: `busy`, `done`, `acc_clr`, `acc_en`, `row_commit` are 0. `row_idx`, `col_idx`, `nz_idx` are 0.
- `start` is sampled at cycle 0; CLR for row 0 is cycle 1.
- Each row costs 2 + nnz(row) + (stall cycles) cycles.
- With `ready` held at 1, the pass occupies cycles 1..(2·`ROW_CNT`+`NNZ`), and `done` is in the following cycle. With default parameters: cycles 1..83, `done` at cycle 84, IDLE at cycle 85.
- `busy` is 1 in cycles 1..84 (CLR through DONE inclusive).
- Minimum `start`-to-`start` spacing is 85 cycles.

## Test plan
- Defaults, `ready`=1, single `start` pulse:
  - Row 0 emits `acc_clr` at cycle 1.
  - `acc_en` in cycles 2..15 with `col_idx` = 0,2,3,4,12,17,18,22,23,26,28,29,30,39 and `nz_idx` = 0..13.
  - `row_commit` with `row_idx`=0 at cycle 16.
  - `done` only at cycle 84. Total `acc_en` count is 71.
- Backpressure: drop `ready` for 3 cycles at `nz_idx`=5 → `acc_en`, `col_idx`=17 and `nz_idx`=5 held stable for 4 cycles; `done` moves to cycle 87. No index is skipped or duplicated.
- Empty row: `ROW_PTRS` with rows 2 and 3 equal (e.g. 0x16,0x16) → row 2 shows `acc_clr` followed directly by `row_commit`, with no `acc_en`.
- Reset mid-WALK at row 3: next cycle all outputs are 0 and the FSM is in IDLE. A subsequent `start` restarts at row 0, `nz_idx`=0.
- `start` asserted while busy, and held through DONE:
  - No effect while busy.
  - A new pass begins with `acc_clr` 2 cycles after `done`.
- `ROW_CNT`=1, `NNZ`=1: the sequence is `acc_clr`, `acc_en`, `row_commit`, `done` on cycles 1 through 4.
